// File: rtl/response_checker_pkg.sv
// Shared types and helpers for the response checker: FSM state encoding and a
// width-aware saturating increment used by the error counter.
package response_checker_pkg;

    typedef enum logic [1:0] {CHK_IDLE, CHK_RUN, CHK_DONE} chk_state_e;

    localparam int unsigned CHK_MAX_CNT_W = 32;

    // Saturates at the all-ones value of a 'width'-bit counter carried in a 32-bit word.
    function automatic logic [CHK_MAX_CNT_W-1:0] sat_inc(
        input logic [CHK_MAX_CNT_W-1:0] val,
        input int unsigned              width
    );
        logic [CHK_MAX_CNT_W-1:0] max_val;
        if (width >= CHK_MAX_CNT_W) begin
            max_val = '1;
        end else begin
            max_val = (CHK_MAX_CNT_W'(1) << width) - CHK_MAX_CNT_W'(1);
        end
        return (val >= max_val) ? max_val : val + CHK_MAX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/response_checker_err_log.sv
// chk_err_log: small show-ahead FIFO holding the sample indices of mismatches.
// Synchronous clear empties it; push while full is accepted only if a pop frees a slot.
module chk_err_log #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              r_n,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty && !i_clr;
    // A simultaneous pop frees the slot the push is about to fill.
    assign w_do_push = i_push && (!w_full || i_pop) && !i_clr;

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(w_do_push);
            r_rd_ptr <= r_rd_ptr + (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign o_vld  = !w_empty;
    assign o_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_full = w_full;

endmodule

// File: rtl/response_checker.sv
// response_checker: compares paired reference/DUT samples over a fixed-length run.
// Define CHK_ERRLOG_EN to add the mismatch-index log (log_vld/log_idx/log_ovf/log_pop).
module response_checker #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned NUM_SAMPLES = 100,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LOG_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             start,
    input  logic             sample_vld,
    input  logic [WIDTH-1:0] ref_data,
    input  logic [WIDTH-1:0] dut_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_lanes,
    output logic [WIDTH-1:0] lane_err,
    output logic             log_vld,
    output logic [CNT_W-1:0] log_idx,
    output logic             log_ovf,
    input  logic             log_pop
);

    import response_checker_pkg::*;

    if (CNT_W < 1 || CNT_W > CHK_MAX_CNT_W) begin : g_bad_cnt_w
        $error("response_checker: CNT_W must be in 1..%0d", CHK_MAX_CNT_W);
    end
    if (NUM_SAMPLES < 1 || (64'(NUM_SAMPLES) >> CNT_W) != 64'd0) begin : g_bad_num_samples
        $error("response_checker: NUM_SAMPLES must satisfy 1 <= NUM_SAMPLES < 2**CNT_W");
    end
    if (LOG_DEPTH < 2 || (LOG_DEPTH & (LOG_DEPTH - 1)) != 0) begin : g_bad_log_depth
        $error("response_checker: LOG_DEPTH must be a power of two >= 2");
    end

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    chk_state_e       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_first_err_idx;
    logic [WIDTH-1:0] r_first_err_lanes;
    logic [WIDTH-1:0] r_lane_err;

    logic [WIDTH-1:0] w_diff;
    logic             w_mismatch;
    logic             w_accept;
    logic             w_last;
    logic             w_restart;

    assign w_diff     = ref_data ^ dut_data;
    assign w_mismatch = |w_diff;
    assign w_accept   = sample_vld && (r_state == CHK_RUN);
    assign w_last     = w_accept && (r_sample_cnt == LAST_IDX);
    assign w_restart  = start && (r_state != CHK_RUN);

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            r_state           <= CHK_IDLE;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_sample_cnt      <= '0;
            r_err_cnt         <= '0;
            r_first_err_idx   <= '0;
            r_first_err_lanes <= '0;
            r_lane_err        <= '0;
        end else begin
            case (r_state)
                CHK_IDLE, CHK_DONE: begin
                    if (start) begin
                        r_state           <= CHK_RUN;
                        r_busy            <= 1'b1;
                        r_done            <= 1'b0;
                        r_pass            <= 1'b0;
                        r_sample_cnt      <= '0;
                        r_err_cnt         <= '0;
                        r_first_err_idx   <= '0;
                        r_first_err_lanes <= '0;
                        r_lane_err        <= '0;
                    end
                end
                CHK_RUN: begin
                    if (w_accept) begin
                        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                        r_lane_err   <= r_lane_err | w_diff;
                        if (w_mismatch) begin
                            r_err_cnt <= CNT_W'(sat_inc(CHK_MAX_CNT_W'(r_err_cnt), CNT_W));
                            if (r_err_cnt == '0) begin
                                r_first_err_idx   <= r_sample_cnt;
                                r_first_err_lanes <= w_diff;
                            end
                        end
                        if (w_last) begin
                            r_state <= CHK_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            // Pass must account for the final sample's own compare result.
                            r_pass  <= (r_err_cnt == '0) && !w_mismatch;
                        end
                    end
                end
                default: begin
                    r_state <= CHK_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign sample_cnt      = r_sample_cnt;
    assign err_cnt         = r_err_cnt;
    assign first_err_idx   = r_first_err_idx;
    assign first_err_lanes = r_first_err_lanes;
    assign lane_err        = r_lane_err;

`ifdef CHK_ERRLOG_EN
    logic             r_log_ovf;
    logic             w_log_push;
    logic             w_log_full;
    logic             w_log_vld;
    logic [CNT_W-1:0] w_log_idx;

    assign w_log_push = w_accept && w_mismatch;

    chk_err_log #(
        .DATA_W (CNT_W),
        .DEPTH  (LOG_DEPTH)
    ) u_err_log (
        .clk    (clk),
        .r_n    (r_n),
        .i_clr  (w_restart),
        .i_push (w_log_push),
        .i_data (r_sample_cnt),
        .i_pop  (log_pop),
        .o_vld  (w_log_vld),
        .o_data (w_log_idx),
        .o_full (w_log_full)
    );

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            r_log_ovf <= 1'b0;
        end else if (w_restart) begin
            r_log_ovf <= 1'b0;
        end else if (w_log_push && w_log_full && !log_pop) begin
            r_log_ovf <= 1'b1;
        end
    end

    assign log_vld = w_log_vld;
    assign log_idx = w_log_idx;
    assign log_ovf = r_log_ovf;
`else
    logic w_unused_log;
    assign w_unused_log = &{1'b0, log_pop, w_restart};

    assign log_vld = 1'b0;
    assign log_idx = '0;
    assign log_ovf = 1'b0;
`endif

endmodule
